// File: rtl/ssidft_pkg.sv
// Shared types and the per-bin term helper for the single-sample inverse DFT.
// The term is computed at a fixed 32-bit width; callers size it to their accumulator.
package ssidft_pkg;

    localparam int TERM_W = 32;

    typedef enum logic {
        MODE_X0    = 1'b0,
        MODE_XHALF = 1'b1
    } mode_e;

    // x[N/2] uses (-1)^k, so odd bins are subtracted in that mode only.
    function automatic logic signed [TERM_W-1:0] ssidft_term(
        input logic signed [TERM_W-1:0] i_val,
        input logic                     i_idx_lsb,
        input mode_e                    i_mode
    );
        ssidft_term = (i_mode == MODE_XHALF && i_idx_lsb) ? -i_val : i_val;
    endfunction

endpackage

// File: rtl/sat_sdft.sv
// Signed saturation from IW to OW bits with a clip flag; purely combinational.
// No handshake: the output follows the input in the same cycle.
module sat_sdft #(
    parameter int IW = 19,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] i_din,
    output logic signed [OW-1:0] o_dout,
    output logic                 o_sat
);

    generate
        if (IW > OW) begin : g_clip
            logic [IW-OW:0] w_hi;
            logic           w_ovf;

            // In range only when every bit from OW-1 upward matches the sign.
            assign w_hi  = i_din[IW-1:OW-1];
            assign w_ovf = ~((&w_hi) | ~(|w_hi));

            always_comb begin
                o_sat = w_ovf;
                if (!w_ovf) begin
                    o_dout = i_din[OW-1:0];
                end else if (i_din[IW-1]) begin
                    o_dout = {1'b1, {(OW-1){1'b0}}};
                end else begin
                    o_dout = {1'b0, {(OW-1){1'b1}}};
                end
            end
        end else begin : g_pass
            assign o_dout = OW'(i_din);
            assign o_sat  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ssidft_mc.sv
// Multi-channel single-sample inverse DFT (x[0] or x[N/2]) over interleaved bin frames.
// Sample 2 cycles after eob, error flag 1 cycle after the bin; one bin/cycle, no backpressure.
module ssidft_mc
    import ssidft_pkg::*;
#(
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int N     = 4096,
    parameter int AW    = $clog2(N),
    parameter int CH    = 4,
    parameter int CW    = (CH > 1) ? $clog2(CH) : 1,
    parameter int SHIFT = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bin_valid_i,
    input  logic [CW-1:0]        ch_i,
    input  logic                 sob_i,
    input  logic                 eob_i,
    input  logic                 mode_i,
    input  logic signed [DW-1:0] freq_re_i,
    output logic signed [OW-1:0] sample_o,
    output logic [CW-1:0]        sample_ch_o,
    output logic                 sample_en_o,
    output logic                 sat_o,
    output logic                 err_o,
    output logic [CW-1:0]        err_ch_o
);

    localparam int            ACCW     = DW + AW;
    localparam int            SW       = ACCW - SHIFT;
    localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

    logic                   r_active [CH];
    logic [AW-1:0]          r_cnt    [CH];
    mode_e                  r_mode   [CH];
    logic signed [ACCW-1:0] r_acc    [CH];

    logic                   w_cur_active;
    logic [AW-1:0]          w_cur_cnt;
    mode_e                  w_cur_mode;
    logic signed [ACCW-1:0] w_cur_acc;
    logic signed [ACCW-1:0] w_bin_ext;
    logic signed [ACCW-1:0] w_term;
    logic signed [ACCW-1:0] w_sum;

    logic                   w_wr;
    logic                   w_err;
    logic                   w_emit;
    logic                   w_nxt_active;
    logic [AW-1:0]          w_nxt_cnt;
    mode_e                  w_nxt_mode;
    logic signed [ACCW-1:0] w_nxt_acc;
    logic signed [ACCW-1:0] w_emit_acc;

    logic                   r_s1_vld;
    logic [CW-1:0]          r_s1_ch;
    logic signed [ACCW-1:0] r_s1_acc;
    logic signed [SW-1:0]   w_s1_shifted;
    logic signed [OW-1:0]   w_sat_dout;
    logic                   w_sat_flag;

    logic signed [OW-1:0]   r_sample;
    logic [CW-1:0]          r_sample_ch;
    logic                   r_sample_en;
    logic                   r_sat;
    logic                   r_err;
    logic [CW-1:0]          r_err_ch;

    assign w_cur_active = r_active[ch_i];
    assign w_cur_cnt    = r_cnt[ch_i];
    assign w_cur_mode   = r_mode[ch_i];
    assign w_cur_acc    = r_acc[ch_i];
    assign w_bin_ext    = ACCW'(freq_re_i);
    assign w_term       = ACCW'(ssidft_term(TERM_W'(freq_re_i), w_cur_cnt[0], w_cur_mode));
    assign w_sum        = w_cur_acc + w_term;

    always_comb begin
        w_wr         = 1'b0;
        w_err        = 1'b0;
        w_emit       = 1'b0;
        w_nxt_active = w_cur_active;
        w_nxt_cnt    = w_cur_cnt;
        w_nxt_mode   = w_cur_mode;
        w_nxt_acc    = w_cur_acc;
        w_emit_acc   = w_sum;
        if (bin_valid_i) begin
            if (sob_i) begin
                // A sob always restarts the channel; a still-open frame is flagged and dropped.
                w_wr         = 1'b1;
                w_err        = w_cur_active;
                w_nxt_acc    = w_bin_ext;
                w_nxt_cnt    = AW'(1);
                w_nxt_mode   = mode_e'(mode_i);
                w_nxt_active = ~eob_i;
                w_emit       = eob_i;
                w_emit_acc   = w_bin_ext;
            end else if (!w_cur_active) begin
                w_err = 1'b1;
            end else begin
                w_wr = 1'b1;
                if (eob_i) begin
                    w_emit       = 1'b1;
                    w_nxt_active = 1'b0;
                    w_nxt_acc    = w_sum;
                    w_nxt_cnt    = w_cur_cnt + AW'(1);
                end else if (w_cur_cnt == CNT_LAST) begin
                    w_err        = 1'b1;
                    w_nxt_active = 1'b0;
                end else begin
                    w_nxt_acc = w_sum;
                    w_nxt_cnt = w_cur_cnt + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CH; i++) begin
                r_active[i] <= 1'b0;
                r_cnt[i]    <= '0;
                r_mode[i]   <= MODE_X0;
                r_acc[i]    <= '0;
            end
        end else if (w_wr) begin
            r_active[ch_i] <= w_nxt_active;
            r_cnt[ch_i]    <= w_nxt_cnt;
            r_mode[ch_i]   <= w_nxt_mode;
            r_acc[ch_i]    <= w_nxt_acc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_vld <= 1'b0;
            r_s1_ch  <= '0;
            r_s1_acc <= '0;
            r_err    <= 1'b0;
            r_err_ch <= '0;
        end else begin
            r_s1_vld <= w_emit;
            r_err    <= w_err;
            if (w_emit) begin
                r_s1_ch  <= ch_i;
                r_s1_acc <= w_emit_acc;
            end
            if (w_err) begin
                r_err_ch <= ch_i;
            end
        end
    end

    assign w_s1_shifted = SW'(r_s1_acc >>> SHIFT);

    sat_sdft #(
        .IW (SW),
        .OW (OW)
    ) u_sat (
        .i_din  (w_s1_shifted),
        .o_dout (w_sat_dout),
        .o_sat  (w_sat_flag)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sample    <= '0;
            r_sample_ch <= '0;
            r_sample_en <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_sample_en <= r_s1_vld;
            if (r_s1_vld) begin
                r_sample    <= w_sat_dout;
                r_sample_ch <= r_s1_ch;
                r_sat       <= w_sat_flag;
            end
        end
    end

    assign sample_o    = r_sample;
    assign sample_ch_o = r_sample_ch;
    assign sample_en_o = r_sample_en;
    assign sat_o       = r_sat;
    assign err_o       = r_err;
    assign err_ch_o    = r_err_ch;

endmodule

// File: doc/ssidft_mc.md
# ssidft_mc

Multi-channel, mode-selectable single-sample inverse DFT. It accepts frames of real frequency bins, time-interleaved across CH channels. For each completed frame it reconstructs one time-domain sample: x[0] (plain sum) or x[N/2] (alternating-sign sum). The sample is scaled by a fixed right shift and saturated to OW bits. The block sits after the per-channel SDFT/spectral-processing stage and feeds the sample-rate output path.

## Interface
Parameters:
- DW, 16: bin width (signed)
- OW, 16: output sample width (signed)
- N, 4096: bins per frame
- AW, $clog2(N): bin counter width
- CH, 4: channel count
- CW, $clog2(CH) (min 1): channel id width
- SHIFT, 5: arithmetic right shift before saturation

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- bin_valid_i  in  1  bin present this cycle
- ch_i  in  CW  channel of the bin
- sob_i  in  1  first bin of frame (qualified by bin_valid_i)
- eob_i  in  1  last bin of frame (qualified by bin_valid_i)
- mode_i  in  1  sampled with sob_i: 0 = x[0], 1 = x[N/2]
- freq_re_i  in  DW  signed bin value
- sample_o  out  OW  signed reconstructed sample
- sample_ch_o  out  CW  channel of sample_o
- sample_en_o  out  1  sample_o valid, one-cycle pulse
- sat_o  out  1  saturation occurred for this sample (valid with sample_en_o)
- err_o  out  1  framing error pulse
- err_ch_o  out  CW  channel of the error

## Operation
- Per-channel state, indexed by ch_i:
  - active flag
  - bin counter, AW bits
  - mode bit
  - signed accumulator, DW+AW bits
- Term per bin: +freq_re_i in mode 0. In mode 1, +freq_re_i for even bin index and −freq_re_i for odd. Bin index is the counter value; the sob bin has index 0.
- sob_i: accumulator ← ±term of bin 0 (i.e. +freq_re_i), counter ← 1, mode latched, active ← 1.
- Bin in an active frame: accumulator ← accumulator ± term, counter ← counter+1.
- eob_i in an active frame, or together with sob_i: the final accumulator goes to the output stage and active ← 0.
  - Frames shorter than N bins are legal; the output is produced normally.
- Output stage: acc >>> SHIFT (arithmetic), saturated to OW signed range. sat_o = 1 when clipped.
- Errors: the bin is dropped, err_o=1, err_ch_o=ch_i. Cases:
  - sob_i while the channel is active: the old frame is aborted with no output; the new frame starts normally.
  - Bin or eob without sob_i while the channel is inactive: the bin is ignored.
  - N-th bin (counter = N−1) arrives without eob_i: the frame is aborted, active ← 0.
- Channels are fully independent. Any interleaving order is allowed, including back-to-back eobs on different channels.
- bin_valid_i=0: no state change. sob_i, eob_i and mode_i are ignored.

## Timing
- Throughput: one bin per cycle, no backpressure.
- Latency: eob bin at cycle t gives sample_en_o at cycle t+2.
  - Stage 1 registers the final accumulation.
  - Stage 2 registers the shifted/saturated result.
- err_o is registered, at t+1 after the offending bin.
- Back-to-back eobs at t and t+1 give sample_en_o pulses at t+2 and t+3.
- Reset values:
  - sample_o, sample_ch_o, sample_en_o, sat_o, err_o, err_ch_o = 0.
  - All active flags, counters, mode bits and accumulators = 0.
- Reset mid-frame: the frame is lost. Any in-flight stage 1/2 result is discarded with no sample_en_o.
- Accumulator width DW+AW cannot overflow for N bins of full-scale input.

## Structure
- Package ssidft_pkg holds:
  - mode enum (MODE_X0=0, MODE_XHALF=1)
  - function computing the signed term from value, bin index LSB and mode
- Per-channel state lives in register arrays; CH is small, so no RAM.
- Saturation reuses the existing sat_sdft sub-module with IW = DW+AW−SHIFT, OW = OW. Its input is acc[DW+AW-1:SHIFT].

## Test plan
All tests use N=8, DW=16, OW=16, CH=4, SHIFT=0 unless stated.
- Ch0, mode 0, 8 bins of 100 → sample_o=800, sample_ch_o=0, sat_o=0, two cycles after eob.
- Ch2, mode 1, bins 100,50,100,50,100,50,100,50 → sample_o=200.
- Ch1 and ch3 interleaved bin-by-bin, mode 0, values 1 and −1, eobs in consecutive cycles:
  - Ch1 output 8, ch3 output −8, on consecutive sample_en_o pulses.
- SHIFT=2, OW=8, mode 0, 8 bins of 32767 → sat_o=1, sample_o=127.
- Framing errors:
  - sob on ch0 mid-frame → err_o with err_ch_o=0; only the second frame's sample is emitted.
  - Bin on an idle channel → err_o; no sample.
  - 8th bin without eob → err_o; no sample.
- Reset asserted asynchronously mid-frame on ch0, then a fresh frame of 8×10 → sample_o=80, with no stale output from before reset.
